l80_uart_fifo: RTL and testbench

Parametrised, buffered full-duplex UART for the light8080 SOC I/O space, with programmable baud divisor, TX/RX FIFOs, sticky error flags and an interrupt request output. It is the successor to the SOC's bare UART: it adds a receiver, buffering on both directions and error reporting. It decodes a contiguous block of five I/O registers at a parametrised base address and runs entirely on clock100. The bus strobes are single-cycle pulses synchronous to clock100, generated by the integrating logic.

---
 rtl/l80_uart_fifo.sv | 256 +++++++++++++++++++++++++
 tb/tb_l80_uart_fifo.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/l80_uart_fifo.sv
// rtl/l80_uart_fifo.sv - buffered full-duplex UART with TX/RX FIFOs for the light8080 I/O space
// Registers at BASE_ADDR+0..4: DATA, BAUDL, BAUDH, STAT, CTRL.

module l80_uart_fifo_queue #(
  parameter int AW = 4
) (
  input  logic       clock100,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int DEPTH = 1 << AW;

  logic [7:0]  mem [0:DEPTH-1];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock100) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clock100 or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

module l80_uart_fifo #(
  parameter logic [7:0]  BASE_ADDR  = 8'h80,
  parameter int          FIFO_AW    = 4,
  parameter logic [15:0] BAUD_RESET = 16'd53
) (
  input  logic       clock100,
  input  logic       reset,
  input  logic [7:0] io_addr,
  input  logic       io_wr,
  input  logic       io_rd,
  input  logic [7:0] io_din,
  output logic [7:0] io_dout,
  input  logic       rxd,
  output logic       txd,
  output logic       irq
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]  off;
  logic        in_blk;
  logic        wr_data, wr_baudl, wr_baudh, wr_ctrl;
  logic        rd_data, rd_stat;
  logic [15:0] baud, baud_new, baud_cnt;
  logic        tick;
  logic [2:0]  ctrl;
  logic        frame_err, rx_ovr, tx_ovr;
  logic        tx_full, tx_empty, tx_pop;
  logic        rx_full, rx_empty, rx_pop, rx_push;
  logic [7:0]  tx_q, rx_q;
  logic [7:0]  stat;

  state_t      tx_state, rx_state;
  logic [7:0]  tx_shift, rx_shift;
  logic [3:0]  tx_tcnt, rx_tcnt;
  logic [2:0]  tx_bcnt, rx_bcnt;
  logic        rx_s1, rx_s2, rx_line;
  logic        tx_busy;

  assign off      = io_addr - BASE_ADDR;
  assign in_blk   = (off < 8'd5);
  assign wr_data  = io_wr & in_blk & (off == 8'd0);
  assign wr_baudl = io_wr & in_blk & (off == 8'd1);
  assign wr_baudh = io_wr & in_blk & (off == 8'd2);
  assign wr_ctrl  = io_wr & in_blk & (off == 8'd4);
  assign rd_data  = io_rd & in_blk & (off == 8'd0);
  assign rd_stat  = io_rd & in_blk & (off == 8'd3);

  always_comb begin
    baud_new = baud;
    if (wr_baudl) baud_new[7:0]  = io_din;
    if (wr_baudh) baud_new[15:8] = io_din;
  end

  assign tick = (baud_cnt == 16'd0);

  always_ff @(posedge clock100 or posedge reset) begin
    if (reset) begin
      baud     <= BAUD_RESET;
      baud_cnt <= BAUD_RESET;
      ctrl     <= 3'd0;
    end else begin
      baud <= baud_new;
      if (wr_baudl | wr_baudh) baud_cnt <= baud_new;
      else if (tick)           baud_cnt <= baud;
      else                     baud_cnt <= baud_cnt - 16'd1;
      if (wr_ctrl) ctrl <= io_din[2:0];
    end
  end

  l80_uart_fifo_queue #(.AW(FIFO_AW)) u_tx_fifo (
    .clock100(clock100), .reset(reset), .push(wr_data), .pop(tx_pop),
    .din(io_din), .dout(tx_q), .full(tx_full), .empty(tx_empty)
  );

  l80_uart_fifo_queue #(.AW(FIFO_AW)) u_rx_fifo (
    .clock100(clock100), .reset(reset), .push(rx_push), .pop(rx_pop),
    .din(rx_shift), .dout(rx_q), .full(rx_full), .empty(rx_empty)
  );

  assign tx_busy = (tx_state != IDLE);
  assign tx_pop  = ~tx_empty & ((tx_state == IDLE) |
                   ((tx_state == STOP) & tick & (tx_tcnt == 4'd15)));

  always_ff @(posedge clock100 or posedge reset) begin
    if (reset) begin
      tx_state <= IDLE;
      tx_shift <= 8'd0;
      tx_tcnt  <= 4'd0;
      tx_bcnt  <= 3'd0;
      txd      <= 1'b1;
    end else begin
      case (tx_state)
        IDLE: if (!tx_empty) begin
          tx_shift <= tx_q;
          tx_tcnt  <= 4'd0;
          txd      <= 1'b0;
          tx_state <= START;
        end
        START: if (tick) begin
          tx_tcnt <= tx_tcnt + 4'd1;
          if (tx_tcnt == 4'd15) begin
            tx_state <= DATA;
            tx_bcnt  <= 3'd0;
            txd      <= tx_shift[0];
          end
        end
        DATA: if (tick) begin
          tx_tcnt <= tx_tcnt + 4'd1;
          if (tx_tcnt == 4'd15) begin
            if (tx_bcnt == 3'd7) begin
              tx_state <= STOP;
              txd      <= 1'b1;
            end else begin
              tx_bcnt  <= tx_bcnt + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              txd      <= tx_shift[1];
            end
          end
        end
        STOP: if (tick) begin
          tx_tcnt <= tx_tcnt + 4'd1;
          if (tx_tcnt == 4'd15) begin
            if (!tx_empty) begin
              tx_shift <= tx_q;
              tx_tcnt  <= 4'd0;
              txd      <= 1'b0;
              tx_state <= START;
            end else begin
              tx_state <= IDLE;
            end
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  // Loopback takes txd directly: it is already a clock100 flop, no synchroniser needed.
  assign rx_line = ctrl[2] ? txd : rx_s2;
  assign rx_push = (rx_state == STOP) & tick & (rx_tcnt == 4'd15);
  assign rx_pop  = rd_data & ~rx_empty;

  always_ff @(posedge clock100 or posedge reset) begin
    if (reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_state <= IDLE;
      rx_shift <= 8'd0;
      rx_tcnt  <= 4'd0;
      rx_bcnt  <= 3'd0;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
      case (rx_state)
        IDLE: if (tick && !rx_line) begin
          rx_tcnt  <= 4'd0;
          rx_state <= START;
        end
        START: if (tick) begin
          if (rx_tcnt == 4'd7) begin
            rx_tcnt  <= 4'd0;
            rx_bcnt  <= 3'd0;
            rx_state <= rx_line ? IDLE : DATA;
          end else begin
            rx_tcnt <= rx_tcnt + 4'd1;
          end
        end
        DATA: if (tick) begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) begin
            rx_shift <= {rx_line, rx_shift[7:1]};
            rx_bcnt  <= rx_bcnt + 3'd1;
            if (rx_bcnt == 3'd7) rx_state <= STOP;
          end
        end
        STOP: if (tick) begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) rx_state <= IDLE;
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  assign stat = {frame_err, rx_ovr, rx_full, ~rx_empty, tx_ovr, tx_busy, tx_empty, tx_full};

  // Set terms are OR-ed after the clear so an event coinciding with a STAT read survives.
  always_ff @(posedge clock100 or posedge reset) begin
    if (reset) begin
      frame_err <= 1'b0;
      rx_ovr    <= 1'b0;
      tx_ovr    <= 1'b0;
      io_dout   <= 8'd0;
      irq       <= 1'b0;
    end else begin
      frame_err <= (rx_push & ~rx_line) | (frame_err & ~rd_stat);
      rx_ovr    <= (rx_push & rx_full & ~rx_pop) | (rx_ovr & ~rd_stat);
      tx_ovr    <= (wr_data & tx_full & ~tx_pop) | (tx_ovr & ~rd_stat);
      if (io_rd && in_blk) begin
        case (off)
          8'd0:    io_dout <= rx_empty ? 8'd0 : rx_q;
          8'd1:    io_dout <= baud[7:0];
          8'd2:    io_dout <= baud[15:8];
          8'd3:    io_dout <= stat;
          default: io_dout <= {5'd0, ctrl};
        endcase
      end
      irq <= (ctrl[0] & ~rx_empty) | (ctrl[1] & tx_empty & ~tx_busy);
    end
  end
endmodule

// File: tb/tb_l80_uart_fifo.sv
// tb/tb_l80_uart_fifo.sv - directed bench for l80_uart_fifo
module tb_l80_uart_fifo;
  logic       clock100 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] io_addr = 8'h00;
  logic       io_wr = 1'b0;
  logic       io_rd = 1'b0;
  logic [7:0] io_din = 8'h00;
  logic [7:0] io_dout;
  logic       rxd = 1'b1;
  logic       txd;
  logic       irq;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [7:0] DATA_A = 8'h80, BAUDL_A = 8'h81, BAUDH_A = 8'h82, STAT_A = 8'h83, CTRL_A = 8'h84;

  l80_uart_fifo dut (
    .clock100(clock100), .reset(reset), .io_addr(io_addr), .io_wr(io_wr), .io_rd(io_rd),
    .io_din(io_din), .io_dout(io_dout), .rxd(rxd), .txd(txd), .irq(irq)
  );

  always #5 clock100 = ~clock100;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    io_addr = a; io_din = d; io_wr = 1'b1;
    @(negedge clock100);
    io_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    io_addr = a; io_rd = 1'b1;
    @(negedge clock100);
    io_rd = 1'b0;
    d = io_dout;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock100);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = frame[i];
      wait_cycles(16);
    end
    rxd = 1'b1;
    wait_cycles(4);
  endtask

  task automatic test_reset;
    logic [7:0] d;
    reset = 1'b1;
    wait_cycles(2);
    vectors++; if (txd !== 1'b1) begin miscompares++; $display("FAIL reset_txd got %b want 1", txd); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got %b want 0", irq); end
    vectors++; if (io_dout !== 8'h00) begin miscompares++; $display("FAIL reset_dout got %h want 00", io_dout); end
    reset = 1'b0;
    wait_cycles(1);
    bus_read(STAT_A, d);
    vectors++; if (d !== 8'h02) begin miscompares++; $display("FAIL reset_stat got %h want 02", d); end
    bus_read(BAUDH_A, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL reset_baudh got %h want 00", d); end
    bus_read(BAUDL_A, d);
    vectors++; if (d !== 8'h35) begin miscompares++; $display("FAIL reset_baudl got %h want 35", d); end
    bus_read(8'h85, d);
    vectors++; if (d !== 8'h35) begin miscompares++; $display("FAIL outside_read_holds got %h want 35", d); end
    bus_read(DATA_A, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL empty_data_read got %h want 00", d); end
    bus_write(CTRL_A, 8'hF8);
    bus_write(8'h7F, 8'h07);
    bus_read(CTRL_A, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL ctrl_upper_bits got %h want 00", d); end
  endtask

  task automatic test_tx_frame;
    logic [9:0] frame;
    logic [7:0] d;
    frame = {1'b1, 8'hA5, 1'b0};
    bus_write(BAUDL_A, 8'h00);
    bus_write(CTRL_A, 8'h02);
    wait_cycles(2);
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL tx_irq_idle got %b want 1", irq); end
    bus_write(DATA_A, 8'hA5);
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 16; c++) begin
        @(negedge clock100);
        vectors++; if (txd !== frame[b]) begin miscompares++; $display("FAIL tx_bit%0d_cyc%0d got %b want %b", b, c, txd, frame[b]); end
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL tx_irq_busy bit%0d got %b want 0", b, irq); end
      end
    end
    wait_cycles(2);
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL tx_irq_after_stop got %b want 1", irq); end
    bus_write(DATA_A, 8'h00);
    wait_cycles(20);
    bus_read(STAT_A, d);
    vectors++; if (d !== 8'h06) begin miscompares++; $display("FAIL tx_stat_busy got %h want 06", d); end
    wait_cycles(180);
    bus_read(STAT_A, d);
    vectors++; if (d !== 8'h02) begin miscompares++; $display("FAIL tx_stat_done got %h want 02", d); end
    bus_write(CTRL_A, 8'h00);
  endtask

  task automatic test_loopback;
    logic [7:0] d;
    logic [7:0] exp [3];
    exp[0] = 8'h3C; exp[1] = 8'hFF; exp[2] = 8'h00;
    bus_write(BAUDL_A, 8'h03);
    bus_write(CTRL_A, 8'h04);
    for (int i = 0; i < 3; i++) bus_write(DATA_A, exp[i]);
    wait_cycles(2400);
    bus_read(STAT_A, d);
    vectors++; if (d !== 8'h12) begin miscompares++; $display("FAIL lb_stat_pending got %h want 12", d); end
    for (int i = 0; i < 3; i++) begin
      bus_read(DATA_A, d);
      vectors++; if (d !== exp[i]) begin miscompares++; $display("FAIL lb_byte%0d got %h want %h", i, d, exp[i]); end
    end
    bus_read(STAT_A, d);
    vectors++; if (d !== 8'h02) begin miscompares++; $display("FAIL lb_stat_after got %h want 02", d); end
    bus_read(DATA_A, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL lb_empty_read got %h want 00", d); end
    bus_write(CTRL_A, 8'h00);
  endtask

  task automatic test_tx_overflow;
    logic [7:0] d;
    bus_write(BAUDL_A, 8'd100);
    for (int i = 0; i < 18; i++) bus_write(DATA_A, 8'(i + 1));
    bus_read(STAT_A, d);
    vectors++; if (d !== 8'h0D) begin miscompares++; $display("FAIL txovr_stat got %h want 0D", d); end
    bus_read(STAT_A, d);
    vectors++; if (d !== 8'h05) begin miscompares++; $display("FAIL txovr_clear got %h want 05", d); end
    reset = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(1);
  endtask

  task automatic test_rx_overrun;
    logic [7:0] d;
    logic [7:0] exp [16];
    bus_write(BAUDL_A, 8'h00);
    bus_write(CTRL_A, 8'h01);
    for (int i = 0; i < 17; i++) begin
      d = 8'(i * 37 + 5);
      if (i < 16) exp[i] = d;
      send_rx(d, 1'b1);
    end
    wait_cycles(20);
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL rx_irq got %b want 1", irq); end
    bus_read(STAT_A, d);
    vectors++; if (d !== 8'h72) begin miscompares++; $display("FAIL rxovr_stat got %h want 72", d); end
    for (int i = 0; i < 16; i++) begin
      bus_read(DATA_A, d);
      vectors++; if (d !== exp[i]) begin miscompares++; $display("FAIL rx_byte%0d got %h want %h", i, d, exp[i]); end
    end
    bus_read(STAT_A, d);
    vectors++; if (d !== 8'h02) begin miscompares++; $display("FAIL rxovr_cleared got %h want 02", d); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL rx_irq_drained got %b want 0", irq); end
    send_rx(8'h5A, 1'b0);
    wait_cycles(40);
    bus_read(STAT_A, d);
    vectors++; if (d !== 8'h92) begin miscompares++; $display("FAIL frame_err_stat got %h want 92", d); end
    bus_read(DATA_A, d);
    vectors++; if (d !== 8'h5A) begin miscompares++; $display("FAIL frame_err_byte got %h want 5A", d); end
    bus_read(STAT_A, d);
    vectors++; if (d !== 8'h02) begin miscompares++; $display("FAIL frame_err_cleared got %h want 02", d); end
    bus_write(CTRL_A, 8'h00);
  endtask

  task automatic test_false_start;
    logic [7:0] d;
    rxd = 1'b0;
    wait_cycles(4);
    rxd = 1'b1;
    wait_cycles(40);
    bus_read(STAT_A, d);
    vectors++; if (d !== 8'h02) begin miscompares++; $display("FAIL false_start_stat got %h want 02", d); end
    send_rx(8'hC3, 1'b1);
    wait_cycles(20);
    bus_read(DATA_A, d);
    vectors++; if (d !== 8'hC3) begin miscompares++; $display("FAIL after_false_start got %h want C3", d); end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] d;
    bus_write(DATA_A, 8'h55);
    wait_cycles(40);
    vectors++; if (txd !== 1'b0) begin miscompares++; $display("FAIL midframe_txd got %b want 0", txd); end
    #2 reset = 1'b1;
    #1;
    vectors++; if (txd !== 1'b1) begin miscompares++; $display("FAIL async_reset_txd got %b want 1", txd); end
    @(negedge clock100);
    reset = 1'b0;
    wait_cycles(1);
    bus_read(STAT_A, d);
    vectors++; if (d !== 8'h02) begin miscompares++; $display("FAIL post_reset_stat got %h want 02", d); end
    bus_read(BAUDL_A, d);
    vectors++; if (d !== 8'h35) begin miscompares++; $display("FAIL post_reset_baud got %h want 35", d); end
    bus_write(BAUDL_A, 8'h00);
    bus_write(CTRL_A, 8'h04);
    bus_write(DATA_A, 8'h96);
    wait_cycles(200);
    bus_read(DATA_A, d);
    vectors++; if (d !== 8'h96) begin miscompares++; $display("FAIL post_reset_tx got %h want 96", d); end
    bus_read(STAT_A, d);
    vectors++; if (d !== 8'h02) begin miscompares++; $display("FAIL post_reset_tx_stat got %h want 02", d); end
  endtask

  initial begin
    @(negedge clock100);
    test_reset;
    test_tx_frame;
    test_loopback;
    test_tx_overflow;
    test_rx_overrun;
    test_false_start;
    test_reset_midframe;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
